// File: rtl/nukv_value_serializer.sv
// nukv_value_serializer
// Takes FWFT words from the nukv BRAM FIFO wrapper. Each word is {len, payload}.
// The first len payload beats go out LSB beat first, one per cycle, on a narrow
// AXI-Stream with tlast. Words with len==0 or len>BEATS are consumed and dropped.
// Word and drop counts are kept for the debug register file.
module nukv_value_serializer #(
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4,
  parameter int LEN_BITS   = 3,
  parameter int CNT_BITS   = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [LEN_BITS+BEATS*BEAT_WIDTH-1:0] s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic [BEAT_WIDTH-1:0]               m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [CNT_BITS-1:0]                 stat_words,
  output logic [CNT_BITS-1:0]                 stat_dropped
);

  localparam int PAY_W = BEATS * BEAT_WIDTH;
  localparam logic [LEN_BITS-1:0] BEATS_L = LEN_BITS'(BEATS);
  localparam logic [LEN_BITS-1:0] ONE_L   = LEN_BITS'(1);

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } state_t;

  state_t              state;
  logic [1:0]          warm;
  logic                warm_done;
  logic [PAY_W-1:0]    payload;
  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS-1:0] idx;
  logic [LEN_BITS-1:0] next_idx;
  logic [LEN_BITS-1:0] in_len;
  logic                in_ok;
  logic                accept;
  logic                beat_xfer;
  logic                last_next;
  logic [BEAT_WIDTH-1:0] next_beat;

  assign in_len    = s_axis_tdata[LEN_BITS+PAY_W-1 -: LEN_BITS];
  assign in_ok     = (in_len != '0) && (in_len <= BEATS_L);
  assign warm_done = warm[1];
  assign beat_xfer = m_axis_tvalid & m_axis_tready;
  assign accept    = s_axis_tvalid & s_axis_tready;
  assign next_idx  = idx + ONE_L;
  assign last_next = (next_idx == (len_q - ONE_L));

  // Ready is withheld during the post-reset warm-up; afterwards it is open in IDLE
  // or when the final beat of the current word leaves this cycle (no bubble).
  assign s_axis_tready = warm_done &
                         ((state == IDLE) |
                          ((state == SEND) & m_axis_tvalid & m_axis_tlast & m_axis_tready));

  // Select the beat that follows the one currently on the output.
  always_comb begin
    next_beat = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (next_idx == LEN_BITS'(i)) begin
        next_beat = payload[i*BEAT_WIDTH +: BEAT_WIDTH];
      end
    end
  end

  // Two-cycle warm-up after reset release before the first word may be taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm <= 2'd0;
    end else if (!warm_done) begin
      warm <= warm + 2'd1;
    end
  end

  // Serializer FSM: loads accepted words, steps through beats, counts words and drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      payload       <= '0;
      len_q         <= '0;
      idx           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      stat_words    <= '0;
      stat_dropped  <= '0;
    end else if (accept && in_ok) begin
      state         <= SEND;
      payload       <= s_axis_tdata[PAY_W-1:0];
      len_q         <= in_len;
      idx           <= '0;
      m_axis_tdata  <= s_axis_tdata[BEAT_WIDTH-1:0];
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= (in_len == ONE_L);
      stat_words    <= stat_words + CNT_BITS'(1);
    end else if (accept) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      stat_dropped  <= stat_dropped + CNT_BITS'(1);
    end else if ((state == SEND) && beat_xfer) begin
      if (m_axis_tlast) begin
        state         <= IDLE;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end else begin
        idx           <= next_idx;
        m_axis_tdata  <= next_beat;
        m_axis_tlast  <= last_next;
      end
    end
  end

endmodule

// File: tb/tb_nukv_value_serializer.sv
// Testbench for nukv_value_serializer: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_nukv_value_serializer;

  localparam int BW = 64;
  localparam int NB = 4;
  localparam int LB = 3;
  localparam int CB = 6;
  localparam int DW = LB + NB * BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_tready = 1'b1;
  logic [CB-1:0] stat_words;
  logic [CB-1:0] stat_dropped;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } model_beat_t;

  typedef struct {
    logic [BW-1:0] data;
    logic          last;
    logic          rdy;
    int            cyc;
  } cap_t;

  model_beat_t mq[$];
  cap_t        capq[$];
  int          acc_cyc_q[$];
  int          warm = 0;
  int          exp_words = 0;
  int          exp_dropped = 0;
  logic        acc_flag = 1'b0;

  nukv_value_serializer #(
    .BEAT_WIDTH(BW),
    .BEATS(NB),
    .LEN_BITS(LB),
    .CNT_BITS(CB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tdata(s_data),
    .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .m_axis_tdata(m_data),
    .m_axis_tvalid(m_valid),
    .m_axis_tlast(m_last),
    .m_axis_tready(m_tready),
    .stat_words(stat_words),
    .stat_dropped(stat_dropped)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Spec-level ready: warmed up, and either nothing pending or the final beat leaves now.
  function automatic bit exp_ready();
    return (warm >= 2) && ((mq.size() == 0) || (mq[0].last && m_tready));
  endfunction

  // Reference model: a queue of pending beats plus word/drop counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      warm = 0;
      exp_words = 0;
      exp_dropped = 0;
      acc_flag = 1'b0;
    end else begin
      bit rdy;
      bit xfer;
      int len;
      model_beat_t b;
      cyc++;
      rdy = exp_ready();
      xfer = (mq.size() != 0) && m_tready;
      acc_flag = s_valid && rdy;
      if (xfer) void'(mq.pop_front());
      if (acc_flag) begin
        acc_cyc_q.push_back(cyc);
        len = int'(s_data[DW-1 -: LB]);
        if (len >= 1 && len <= NB) begin
          for (int i = 0; i < len; i++) begin
            b.data = s_data[i*BW +: BW];
            b.last = (i == len - 1);
            mq.push_back(b);
          end
          exp_words = (exp_words + 1) % (1 << CB);
        end else begin
          exp_dropped = (exp_dropped + 1) % (1 << CB);
        end
      end
      if (warm < 2) warm++;
    end
  end

  // Compare DUT against the model every cycle, and capture every beat transfer.
  always @(negedge clk) begin
    checkOutput("tvalid", 64'(m_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkOutput("tdata", m_data, mq[0].data);
      checkOutput("tlast", 64'(m_last), 64'(mq[0].last));
    end
    checkOutput("s_tready", 64'(s_ready), 64'(exp_ready()));
    checkOutput("stat_words", 64'(stat_words), 64'(exp_words));
    checkOutput("stat_dropped", 64'(stat_dropped), 64'(exp_dropped));
    if (rst_n && m_valid && m_tready) begin
      cap_t c;
      c.data = m_data;
      c.last = m_last;
      c.rdy  = s_ready;
      c.cyc  = cyc;
      capq.push_back(c);
    end
  end

  // Present one word and hold it until consumed (called at posedge+1).
  task automatic applyStimulus(input logic [LB-1:0] len, input logic [NB*BW-1:0] pl);
    int n;
    s_valid = 1'b1;
    s_data  = {len, pl};
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_flag && n < 64);
    if (!acc_flag) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=none required=accept within 64 cycles");
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NB*BW-1:0] rand_pl();
    logic [NB*BW-1:0] v;
    for (int i = 0; i < NB * BW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [LB-1:0] rand_len();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return LB'($urandom_range(1, NB));
    r = $urandom_range(0, 3);
    return (r == 0) ? LB'(0) : LB'(NB + r);
  endfunction

  function automatic int first_acc();
    return (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : -1;
  endfunction

  logic [BW-1:0] va, vb, vc, vd;
  int c0;
  bit pat [5];

  initial begin
    va = 64'hAAAA_0000_1111_000A;
    vb = 64'hBBBB_0000_2222_000B;
    vc = 64'hCCCC_0000_3333_000C;
    vd = 64'hDDDD_0000_4444_000D;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset values
    #23;
    checkOutput("rst_tvalid", 64'(m_valid), 64'd0);
    checkOutput("rst_tlast", 64'(m_last), 64'd0);
    checkOutput("rst_tdata", m_data, 64'd0);
    checkOutput("rst_s_tready", 64'(s_ready), 64'd0);
    checkOutput("rst_stat_words", 64'(stat_words), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    c0 = cyc;

    // Full word, also timing of first accept after release
    capq.delete();
    acc_cyc_q.delete();
    applyStimulus(LB'(4), {vd, vc, vb, va});
    s_valid = 1'b0;
    waitCycles(6);
    checkOutput("startup_accept_cycle", 64'(first_acc() - c0), 64'd3);
    checkOutput("full_count", 64'(capq.size()), 64'd4);
    if (capq.size() == 4) begin
      checkOutput("full_b0", capq[0].data, va);
      checkOutput("full_b1", capq[1].data, vb);
      checkOutput("full_b2", capq[2].data, vc);
      checkOutput("full_b3", capq[3].data, vd);
      checkOutput("full_lat", 64'(capq[0].cyc - first_acc()), 64'd0);
      for (int i = 0; i < 4; i++) begin
        checkOutput("full_last", 64'(capq[i].last), 64'(i == 3));
        checkOutput("full_gap", 64'(capq[i].cyc - capq[0].cyc), 64'(i));
      end
    end
    checkOutput("full_stat_words", 64'(stat_words), 64'd1);

    // Back-to-back words; upper beats of the short word must be ignored
    capq.delete();
    applyStimulus(LB'(2), {64'hE0, 64'hE1, 64'd2, 64'd1});
    applyStimulus(LB'(1), {64'hDEAD, 64'hBEEF, 64'hF00D, 64'd3});
    s_valid = 1'b0;
    waitCycles(5);
    checkOutput("b2b_count", 64'(capq.size()), 64'd3);
    if (capq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("b2b_data", capq[i].data, 64'(i + 1));
        checkOutput("b2b_last", 64'(capq[i].last), 64'(i != 0));
        checkOutput("b2b_gap", 64'(capq[i].cyc - capq[0].cyc), 64'(i));
      end
      checkOutput("b2b_ready_b1", 64'(capq[0].rdy), 64'd0);
      checkOutput("b2b_ready_b2", 64'(capq[1].rdy), 64'd1);
    end

    // Backpressure: tready pattern 1,0,0,1,1 starting with beat 0 on the output
    capq.delete();
    applyStimulus(LB'(3), {64'h99, vc, vb, va});
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_tready = pat[i];
      if (i == 1 || i == 2) begin
        checkOutput("bp_hold_data", m_data, vb);
        checkOutput("bp_hold_valid", 64'(m_valid), 64'd1);
      end
      @(posedge clk);
      #1;
    end
    m_tready = 1'b1;
    waitCycles(4);
    checkOutput("bp_count", 64'(capq.size()), 64'd3);
    if (capq.size() == 3) begin
      checkOutput("bp_b0", capq[0].data, va);
      checkOutput("bp_b1", capq[1].data, vb);
      checkOutput("bp_b2", capq[2].data, vc);
      checkOutput("bp_b1_cycle", 64'(capq[1].cyc - capq[0].cyc), 64'd3);
      checkOutput("bp_last", 64'(capq[2].last), 64'd1);
    end

    // Drops: len=0 then len=5, consumed on consecutive cycles with no output
    capq.delete();
    acc_cyc_q.delete();
    applyStimulus(LB'(0), rand_pl());
    applyStimulus(LB'(5), rand_pl());
    s_valid = 1'b0;
    waitCycles(4);
    checkOutput("drop_beats", 64'(capq.size()), 64'd0);
    checkOutput("drop_stat", 64'(stat_dropped), 64'd2);
    checkOutput("drop_words", 64'(stat_words), 64'd4);
    if (acc_cyc_q.size() == 2)
      checkOutput("drop_spacing", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd1);
    else
      checkOutput("drop_accepts", 64'(acc_cyc_q.size()), 64'd2);

    // Counter wrap (6-bit counters): 4 + 59 = 63, one more wraps to 0
    for (int k = 0; k < 59; k++) applyStimulus(LB'(1), {192'd0, 64'(k)});
    s_valid = 1'b0;
    waitCycles(3);
    checkOutput("wrap_pre", 64'(stat_words), 64'd63);
    applyStimulus(LB'(1), {192'd0, 64'h77});
    s_valid = 1'b0;
    waitCycles(3);
    checkOutput("wrap_post", 64'(stat_words), 64'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if (!s_valid || acc_flag) begin
        if ($urandom_range(0, 9) < 7) begin
          s_valid = 1'b1;
          s_data  = {rand_len(), rand_pl()};
        end else begin
          s_valid = 1'b0;
        end
      end
      m_tready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_tready = 1'b1;
    waitCycles(10);

    // Asynchronous reset in the middle of a stalled word
    m_tready = 1'b0;
    applyStimulus(LB'(4), rand_pl());
    s_valid = 1'b0;
    waitCycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tvalid", 64'(m_valid), 64'd0);
    checkOutput("mid_rst_tlast", 64'(m_last), 64'd0);
    checkOutput("mid_rst_tdata", m_data, 64'd0);
    checkOutput("mid_rst_words", 64'(stat_words), 64'd0);
    checkOutput("mid_rst_dropped", 64'(stat_dropped), 64'd0);
    checkOutput("mid_rst_s_tready", 64'(s_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    c0 = cyc;
    m_tready = 1'b1;
    capq.delete();
    acc_cyc_q.delete();
    applyStimulus(LB'(1), {192'd0, 64'h1234});
    s_valid = 1'b0;
    waitCycles(4);
    checkOutput("rst2_accept_cycle", 64'(first_acc() - c0), 64'd3);
    checkOutput("rst2_count", 64'(capq.size()), 64'd1);
    if (capq.size() == 1) checkOutput("rst2_data", capq[0].data, 64'h1234);
    checkOutput("rst2_words", 64'(stat_words), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
